gpu_video_timing: RTL and testbench

- Display timing generator directly downstream of the GP1 register front end.
- Consumes GP1 display-mode and display-range registers; runs horizontal and vertical counters in GPU clock ticks.
- Produces blanking, sync, dot-clock enable, pixel/line coordinates, interlace field and status bit 31 for the scan-out path and the status word.

---
 rtl/gpu_video_timing.sv | 204 ++++++++++++++++++++
 tb/tb_gpu_video_timing.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_video_timing.sv
// gpu_video_timing: display timing generator fed by the GP1 display-mode and
// display-range registers. Horizontal and vertical counters run in GPU clock
// ticks. The block produces blanking, sync, a dot enable, the dot index, the
// interlace field, GPUSTAT bit 31 and a vblank interrupt pulse.
//
// Build option GPU_VIDEO_TIMING_DOTCLK_EN:
//   - defined:   o_dotClk is a free-running pulse, one cycle per dot-divider
//                period, independent of blanking (root-counter dot source).
//   - undefined: o_dotClk is tied low and the free-running divider is absent.
//
// Timing of the registered outputs: hBlank, vBlank, dotEn, pixX and
// vblankIrq describe the counter position of the previous cycle. hCount,
// vCount, hSync and vSync describe the current position.
module gpu_video_timing #(
   parameter int NTSC_LINE_CLKS = 3413,
   parameter int PAL_LINE_CLKS  = 3406,
   parameter int NTSC_LINES     = 263,
   parameter int PAL_LINES      = 314,
   parameter int HSYNC_CLKS     = 200
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_videoMode,
   input  logic        i_isInterlaced,
   input  logic        i_verticalRes,
   input  logic [1:0]  i_horizRes,
   input  logic        i_horizRes368,
   input  logic [11:0] i_rangeX0,
   input  logic [11:0] i_rangeX1,
   input  logic [9:0]  i_rangeY0,
   input  logic [9:0]  i_rangeY1,
   output logic [11:0] o_hCount,
   output logic [9:0]  o_vCount,
   output logic        o_hBlank,
   output logic        o_vBlank,
   output logic        o_hSync,
   output logic        o_vSync,
   output logic        o_dotEn,
   output logic [9:0]  o_pixX,
   output logic        o_field,
   output logic        o_statusBit31,
   output logic        o_vblankIrq,
   output logic        o_dotClk
);

   localparam logic [11:0] NTSC_H_LAST = 12'(NTSC_LINE_CLKS - 1);
   localparam logic [11:0] PAL_H_LAST  = 12'(PAL_LINE_CLKS - 1);
   localparam logic [9:0]  NTSC_V_LAST = 10'(NTSC_LINES - 1);
   localparam logic [9:0]  PAL_V_LAST  = 10'(PAL_LINES - 1);
   localparam logic [11:0] HSYNC_LEN   = 12'(HSYNC_CLKS);
   localparam logic [3:0]  RESET_DIV   = 4'd10;

   // GPU clocks per dot for the selected horizontal resolution.
   function automatic logic [3:0] dotDivider(input logic [1:0] res, input logic res368);
      logic [3:0] d;
      case (res)
         2'd0:    d = 4'd10;
         2'd1:    d = 4'd8;
         2'd2:    d = 4'd5;
         default: d = 4'd4;
      endcase
      if (res368) d = 4'd7;
      return d;
   endfunction

   logic        palMode;
   logic [11:0] hCount;
   logic [9:0]  vCount;
   logic [11:0] lineLast;
   logic [9:0]  fieldLast;
   logic        lineWrap;
   logic        frameWrap;
   logic        hActive;
   logic        vActive;
   logic        lineStart;
   logic [3:0]  selDiv;
   logic [3:0]  divLen;
   logic [3:0]  divCnt;
   logic [3:0]  phaseNow;
   logic [3:0]  effDiv;
   logic [3:0]  divCntNext;
   logic        hBlankR;
   logic        vBlankR;
   logic        dotEnR;
   logic [9:0]  pixXR;
   logic        fieldR;
   logic        lineFlagR;
   logic        irqR;

   // Wrap points, range compares against the live registers, and dot phase.
   // At the display start the divider restarts at phase 0 with the newly
   // selected period, so the first dot of a line lands exactly on X0.
   always_comb begin
      lineLast   = palMode ? PAL_H_LAST : NTSC_H_LAST;
      fieldLast  = palMode ? PAL_V_LAST : NTSC_V_LAST;
      lineWrap   = (hCount == lineLast);
      frameWrap  = lineWrap && (vCount == fieldLast);
      hActive    = (i_rangeX1 > i_rangeX0) && (hCount >= i_rangeX0) && (hCount < i_rangeX1);
      vActive    = (i_rangeY1 > i_rangeY0) && (vCount >= i_rangeY0) && (vCount < i_rangeY1);
      lineStart  = (hCount == i_rangeX0);
      selDiv     = dotDivider(i_horizRes, i_horizRes368);
      phaseNow   = lineStart ? 4'd0 : divCnt;
      effDiv     = lineStart ? selDiv : divLen;
      divCntNext = (phaseNow == effDiv - 4'd1) ? 4'd0 : phaseNow + 4'd1;
   end

   // Line/field counters. The video standard is sampled only at the frame
   // origin, so a mid-frame change of i_videoMode takes effect next frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hCount  <= '0;
         vCount  <= '0;
         palMode <= 1'b0;
      end else begin
         if (hCount == 12'd0 && vCount == 10'd0) palMode <= i_videoMode;
         if (lineWrap) begin
            hCount <= '0;
            vCount <= frameWrap ? 10'd0 : vCount + 10'd1;
         end else begin
            hCount <= hCount + 12'd1;
         end
      end
   end

   // Dot divider: period re-latched and phase restarted at the display start.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         divLen <= RESET_DIV;
         divCnt <= '0;
      end else begin
         if (lineStart) divLen <= selDiv;
         divCnt <= divCntNext;
      end
   end

   // Registered blanking, dot enable, dot index and vblank edge pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hBlankR <= 1'b1;
         vBlankR <= 1'b1;
         dotEnR  <= 1'b0;
         pixXR   <= '0;
         irqR    <= 1'b0;
      end else begin
         hBlankR <= ~hActive;
         vBlankR <= ~vActive;
         dotEnR  <= hActive && (phaseNow == 4'd0);
         irqR    <= ~vActive && ~vBlankR;
         if (lineStart)
            pixXR <= '0;
         else if (dotEnR && pixXR != 10'd1023)
            pixXR <= pixXR + 10'd1;
      end
   end

   // Interlace field and the per-line odd/even flag. The line flag is cleared
   // with the blank value being registered this cycle so it reads 0 whenever
   // o_vBlank reads 1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fieldR    <= 1'b0;
         lineFlagR <= 1'b0;
      end else begin
         if (frameWrap) fieldR <= i_isInterlaced ? ~fieldR : 1'b0;
         if (~vActive)
            lineFlagR <= 1'b0;
         else if (lineWrap)
            lineFlagR <= ~lineFlagR;
      end
   end

`ifdef GPU_VIDEO_TIMING_DOTCLK_EN
   logic [3:0] freeCnt;
   logic       dotClkR;

   // Free-running dot divider for the root counters, ignores blanking.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         freeCnt <= '0;
         dotClkR <= 1'b0;
      end else begin
         dotClkR <= (freeCnt == 4'd0);
         freeCnt <= (freeCnt >= selDiv - 4'd1) ? 4'd0 : freeCnt + 4'd1;
      end
   end

   assign o_dotClk = dotClkR;
`else
   assign o_dotClk = 1'b0;
`endif

   assign o_hCount      = hCount;
   assign o_vCount      = vCount;
   assign o_hBlank      = hBlankR;
   assign o_vBlank      = vBlankR;
   assign o_hSync       = (hCount < HSYNC_LEN);
   assign o_vSync       = (vCount == 10'd0);
   assign o_dotEn       = dotEnR;
   assign o_pixX        = pixXR;
   assign o_field       = fieldR;
   assign o_statusBit31 = (i_isInterlaced && i_verticalRes) ? fieldR : lineFlagR;
   assign o_vblankIrq   = irqR;

endmodule

// File: tb/tb_gpu_video_timing.sv
// Bench for gpu_video_timing. A reduced-size instance (64/48 clocks per line,
// 10/13 lines per field, 6-clock hsync) carries the frame-level sequences; a
// full-size instance covers the real line lengths and the 320-dot line.
module tb_gpu_video_timing;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        videoMode = 1'b0;
   logic        isInterlaced = 1'b0;
   logic        verticalRes = 1'b0;
   logic [1:0]  horizRes = 2'd0;
   logic        horizRes368 = 1'b0;
   logic [11:0] rangeX0 = '0;
   logic [11:0] rangeX1 = '0;
   logic [9:0]  rangeY0 = '0;
   logic [9:0]  rangeY1 = '0;

   logic [11:0] hCount;
   logic [9:0]  vCount;
   logic        hBlank, vBlank, hSync, vSync, dotEn, field, statusBit31, vblankIrq, dotClk;
   logic [9:0]  pixX;

   logic [11:0] fHCount;
   logic [9:0]  fVCount;
   logic        fHBlank, fVBlank, fHSync, fVSync, fDotEn, fField, fStatusBit31, fVblankIrq, fDotClk;
   logic [9:0]  fPixX;

   int curT = 0;
   int nVec = 0;
   int nFail = 0;

   gpu_video_timing #(
      .NTSC_LINE_CLKS(64), .PAL_LINE_CLKS(48), .NTSC_LINES(10), .PAL_LINES(13), .HSYNC_CLKS(6)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_videoMode(videoMode), .i_isInterlaced(isInterlaced),
      .i_verticalRes(verticalRes), .i_horizRes(horizRes), .i_horizRes368(horizRes368),
      .i_rangeX0(rangeX0), .i_rangeX1(rangeX1), .i_rangeY0(rangeY0), .i_rangeY1(rangeY1),
      .o_hCount(hCount), .o_vCount(vCount), .o_hBlank(hBlank), .o_vBlank(vBlank),
      .o_hSync(hSync), .o_vSync(vSync), .o_dotEn(dotEn), .o_pixX(pixX), .o_field(field),
      .o_statusBit31(statusBit31), .o_vblankIrq(vblankIrq), .o_dotClk(dotClk)
   );

   gpu_video_timing dutFull (
      .i_clk(clk), .i_rst(rst), .i_videoMode(videoMode), .i_isInterlaced(isInterlaced),
      .i_verticalRes(verticalRes), .i_horizRes(horizRes), .i_horizRes368(horizRes368),
      .i_rangeX0(rangeX0), .i_rangeX1(rangeX1), .i_rangeY0(rangeY0), .i_rangeY1(rangeY1),
      .o_hCount(fHCount), .o_vCount(fVCount), .o_hBlank(fHBlank), .o_vBlank(fVBlank),
      .o_hSync(fHSync), .o_vSync(fVSync), .o_dotEn(fDotEn), .o_pixX(fPixX), .o_field(fField),
      .o_statusBit31(fStatusBit31), .o_vblankIrq(fVblankIrq), .o_dotClk(fDotClk)
   );

   // Clock: posedge at 5, 15, ...; the bench drives and samples on negedges.
   always #5 clk = ~clk;

   typedef struct {
      int t; int h; int v; int hb; int vb; int hs; int vs; int de; int px; int sb; int irq; int fld;
   } vec_t;

   typedef struct {
      logic [1:0] hr; logic h368; int dots; int gap;
   } dot_t;

   vec_t tabA[19];
   dot_t tabDot[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s t=%0d: got %0d expected %0d", name, curT, act, exp);
      end
   endtask

   task automatic stepTo(input int target);
      while (curT < target) begin
         @(negedge clk);
         curT++;
      end
   endtask

   // Reset for one posedge; on return counters are at the origin and curT=0.
   task automatic doReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      curT = 0;
   endtask

   task automatic setCfg(input logic mode, input logic il, input logic vr, input logic [1:0] hr,
                         input logic h368, input int x0, input int x1, input int y0, input int y1);
      videoMode    = mode;
      isInterlaced = il;
      verticalRes  = vr;
      horizRes     = hr;
      horizRes368  = h368;
      rangeX0      = 12'(x0);
      rangeX1      = 12'(x1);
      rangeY0      = 10'(y0);
      rangeY1      = 10'(y1);
   endtask

   initial begin
      int cnt, cntB, cntC, cntD, firstT, secondT;

      // NTSC, X 8..48, Y 2..7, 256-wide dots (divider 10), progressive.
      //          t    h  v hb vb hs vs de px sb irq fld
      tabA[0]  = '{0,   0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
      tabA[1]  = '{5,   5, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
      tabA[2]  = '{6,   6, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
      tabA[3]  = '{9,   9, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
      tabA[4]  = '{10, 10, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
      tabA[5]  = '{19, 19, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0};
      tabA[6]  = '{48, 48, 0, 0, 1, 0, 1, 0, 4, 0, 0, 0};
      tabA[7]  = '{49, 49, 0, 1, 1, 0, 1, 0, 4, 0, 0, 0};
      tabA[8]  = '{63, 63, 0, 1, 1, 0, 1, 0, 4, 0, 0, 0};
      tabA[9]  = '{64,  0, 1, 1, 1, 1, 0, 0, 4, 0, 0, 0};
      tabA[10] = '{128, 0, 2, 1, 1, 1, 0, 0, 4, 0, 0, 0};
      tabA[11] = '{129, 1, 2, 1, 0, 1, 0, 0, 4, 0, 0, 0};
      tabA[12] = '{192, 0, 3, 1, 0, 1, 0, 0, 4, 1, 0, 0};
      tabA[13] = '{256, 0, 4, 1, 0, 1, 0, 0, 4, 0, 0, 0};
      tabA[14] = '{320, 0, 5, 1, 0, 1, 0, 0, 4, 1, 0, 0};
      tabA[15] = '{449, 1, 7, 1, 1, 1, 0, 0, 4, 0, 1, 0};
      tabA[16] = '{450, 2, 7, 1, 1, 1, 0, 0, 4, 0, 0, 0};
      tabA[17] = '{639,63, 9, 1, 1, 0, 0, 0, 4, 0, 0, 0};
      tabA[18] = '{640, 0, 0, 1, 1, 1, 1, 0, 4, 0, 0, 0};

      // Dots per line in X 8..48 and spacing of the first two dots.
      tabDot[0] = '{2'd0, 1'b0, 4, 10};
      tabDot[1] = '{2'd1, 1'b0, 5, 8};
      tabDot[2] = '{2'd2, 1'b0, 8, 5};
      tabDot[3] = '{2'd3, 1'b0, 10, 4};
      tabDot[4] = '{2'd1, 1'b1, 6, 7};

      // Table A: reset state, line and frame sequencing, progressive line flag.
      setCfg(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8, 48, 2, 7);
      doReset();
      for (int i = 0; i < 19; i++) begin
         stepTo(tabA[i].t);
         chk($sformatf("A%0d.hCount", i), 32'(hCount), tabA[i].h);
         chk($sformatf("A%0d.vCount", i), 32'(vCount), tabA[i].v);
         chk($sformatf("A%0d.hBlank", i), 32'(hBlank), tabA[i].hb);
         chk($sformatf("A%0d.vBlank", i), 32'(vBlank), tabA[i].vb);
         chk($sformatf("A%0d.hSync", i), 32'(hSync), tabA[i].hs);
         chk($sformatf("A%0d.vSync", i), 32'(vSync), tabA[i].vs);
         chk($sformatf("A%0d.dotEn", i), 32'(dotEn), tabA[i].de);
         chk($sformatf("A%0d.pixX", i), 32'(pixX), tabA[i].px);
         chk($sformatf("A%0d.status31", i), 32'(statusBit31), tabA[i].sb);
         chk($sformatf("A%0d.vblankIrq", i), 32'(vblankIrq), tabA[i].irq);
         chk($sformatf("A%0d.field", i), 32'(field), tabA[i].fld);
      end

      // Exactly one vblank interrupt per frame over two frames.
      doReset();
      cnt = 0;
      for (int k = 1; k < 1280; k++) begin
         stepTo(k);
         if (vblankIrq === 1'b1) cnt++;
      end
      chk("irq_per_two_frames", 32'(cnt), 32'd2);

      // Dot divider per resolution: dots in one line, spacing, final pixX.
      for (int i = 0; i < 5; i++) begin
         setCfg(1'b0, 1'b0, 1'b0, tabDot[i].hr, tabDot[i].h368, 8, 48, 2, 7);
         doReset();
         cnt = 0;
         firstT = -1;
         secondT = -1;
         for (int k = 1; k < 64; k++) begin
            stepTo(k);
            if (dotEn === 1'b1) begin
               cnt++;
               if (firstT < 0) firstT = curT;
               else if (secondT < 0) secondT = curT;
            end
         end
         chk($sformatf("D%0d.dots", i), 32'(cnt), 32'(tabDot[i].dots));
         chk($sformatf("D%0d.gap", i), 32'(secondT - firstT), 32'(tabDot[i].gap));
         chk($sformatf("D%0d.pixX", i), 32'(pixX), 32'(tabDot[i].dots));
      end

      // Free-running dot clock, divider 10.
      setCfg(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8, 48, 2, 7);
      doReset();
      cnt = 0;
      for (int k = 1; k <= 64; k++) begin
         stepTo(k);
         if (dotClk === 1'b1) cnt++;
      end
`ifdef GPU_VIDEO_TIMING_DOTCLK_EN
      chk("dotClk_pulses", 32'(cnt), 32'd7);
`else
      chk("dotClk_pulses", 32'(cnt), 32'd0);
`endif

      // NTSC -> PAL switch mid-frame: current frame keeps NTSC geometry.
      doReset();
      stepTo(330);
      videoMode = 1'b1;
      stepTo(383);  chk("M.h383", 32'(hCount), 32'd63);  chk("M.v383", 32'(vCount), 32'd5);
      stepTo(384);  chk("M.h384", 32'(hCount), 32'd0);   chk("M.v384", 32'(vCount), 32'd6);
      stepTo(639);  chk("M.h639", 32'(hCount), 32'd63);  chk("M.v639", 32'(vCount), 32'd9);
      stepTo(640);  chk("M.h640", 32'(hCount), 32'd0);   chk("M.v640", 32'(vCount), 32'd0);
      stepTo(687);  chk("M.h687", 32'(hCount), 32'd47);  chk("M.v687", 32'(vCount), 32'd0);
      stepTo(688);  chk("M.h688", 32'(hCount), 32'd0);   chk("M.v688", 32'(vCount), 32'd1);
      stepTo(1263); chk("M.h1263", 32'(hCount), 32'd47); chk("M.v1263", 32'(vCount), 32'd12);
      stepTo(1264); chk("M.h1264", 32'(hCount), 32'd0);  chk("M.v1264", 32'(vCount), 32'd0);
      videoMode = 1'b0;

      // Interlaced 480: field and status bit 31 toggle once per frame.
      setCfg(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8, 48, 2, 7);
      doReset();
      stepTo(639);  chk("I.field639", 32'(field), 32'd0);  chk("I.sb639", 32'(statusBit31), 32'd0);
      stepTo(640);  chk("I.field640", 32'(field), 32'd1);  chk("I.sb640", 32'(statusBit31), 32'd1);
      stepTo(1279); chk("I.field1279", 32'(field), 32'd1);
      stepTo(1280); chk("I.field1280", 32'(field), 32'd0); chk("I.sb1280", 32'(statusBit31), 32'd0);

      // Reset mid-frame (line 5, clock 20, field 1) and resume.
      doReset();
      stepTo(980);
      chk("R.hBefore", 32'(hCount), 32'd20);
      chk("R.vBefore", 32'(vCount), 32'd5);
      chk("R.fieldBefore", 32'(field), 32'd1);
      chk("R.hBlankBefore", 32'(hBlank), 32'd0);
      chk("R.vBlankBefore", 32'(vBlank), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("R.hCount", 32'(hCount), 32'd0);
      chk("R.vCount", 32'(vCount), 32'd0);
      chk("R.hBlank", 32'(hBlank), 32'd1);
      chk("R.vBlank", 32'(vBlank), 32'd1);
      chk("R.field", 32'(field), 32'd0);
      chk("R.pixX", 32'(pixX), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("R.hResume", 32'(hCount), 32'd1);
      chk("R.vResume", 32'(vCount), 32'd0);
      curT = 1;

      // Empty ranges: X1==X0 and Y1<Y0 keep both blanks high for a frame.
      setCfg(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 20, 20, 8, 3);
      doReset();
      cnt = 0; cntB = 0; cntC = 0; cntD = 0;
      for (int k = 1; k <= 640; k++) begin
         stepTo(k);
         if (hBlank !== 1'b1) cnt++;
         if (dotEn !== 1'b0) cntB++;
         if (vBlank !== 1'b1) cntC++;
         if (vblankIrq !== 1'b0) cntD++;
      end
      chk("E.hBlankLow", 32'(cnt), 32'd0);
      chk("E.dotEn", 32'(cntB), 32'd0);
      chk("E.vBlankLow", 32'(cntC), 32'd0);
      chk("E.irq", 32'(cntD), 32'd0);

      // Full-size NTSC line, 320-wide: 320 dots, last dot index 319 at 0xBF9.
      setCfg(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 12'h200, 12'hC00, 10'h10, 10'h100);
      doReset();
      cnt = 0;
      for (int k = 1; k <= 3412; k++) begin
         stepTo(k);
         if (fDotEn === 1'b1) cnt++;
         if (k == 12'hBF9) begin
            chk("F.dotEnBF9", 32'(fDotEn), 32'd1);
            chk("F.pixXBF9", 32'(fPixX), 32'd319);
         end
      end
      chk("F.dots", 32'(cnt), 32'd320);
      chk("F.h3412", 32'(fHCount), 32'd3412);
      chk("F.v3412", 32'(fVCount), 32'd0);
      stepTo(3413);
      chk("F.h3413", 32'(fHCount), 32'd0);
      chk("F.v3413", 32'(fVCount), 32'd1);

      // Full-size PAL line length.
      videoMode = 1'b1;
      doReset();
      stepTo(3405);
      chk("P.h3405", 32'(fHCount), 32'd3405);
      stepTo(3406);
      chk("P.h3406", 32'(fHCount), 32'd0);
      chk("P.v3406", 32'(fVCount), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
